instruction_fetch_unit: RTL and testbench

// - Upstream sequencer that fetches one 16-bit instruction from byte-wide memory and drives the

---
 rtl/instruction_fetch_unit.sv | 169 ++++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Fetches one little-endian 16-bit instruction from byte-wide memory and drives the IR block.
// Optional IFU_TIMEOUT_EN adds a memory-wait watchdog that aborts a stalled fetch.
module instruction_fetch_unit #(
  parameter logic [15:0] PcReset = 16'h0000,
  parameter int unsigned WaitMax = 15
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        pc_load_i,
  input  logic [15:0] pc_in_i,
  input  logic [7:0]  mem_data_i,
  input  logic        mem_ack_i,
  output logic        mem_rd_o,
  output logic [15:0] mem_addr_o,
  output logic        ir_e_o,
  output logic [2:0]  ir_funsel_o,
  output logic [15:0] ir_data_o,
  output logic [15:0] pc_o,
  output logic        busy_o,
  output logic        ir_valid_o,
  output logic        timeout_o
);

  if (WaitMax < 1 || WaitMax > 255) begin : gen_wait_max_check
    $error("WaitMax must lie in 1..255");
  end

  localparam logic [2:0] FunSelWrLo = 3'b100;
  localparam logic [2:0] FunSelWrHi = 3'b110;

  typedef enum logic [2:0] {
    StIdle,
    StFetchLo,
    StFetchHi,
    StHiWr,
    StDone
  } state_e;

  state_e      state_q;
  logic [15:0] pc_q;
  logic [15:0] mem_addr_q;
  logic [15:0] ir_data_q;
  logic [2:0]  ir_funsel_q;
  logic        mem_rd_q;
  logic        ir_e_q;
  logic        busy_q;
  logic        ir_valid_q;
  logic        timeout_q;
  logic [15:0] pc_inc;

  assign pc_inc = pc_q + 16'd1;

`ifdef IFU_TIMEOUT_EN
  localparam logic [7:0] WaitLast = 8'(WaitMax - 1);

  logic [15:0] start_pc_q;
  logic [7:0]  wait_cnt_q;
  logic        waiting;

  assign waiting = ((state_q == StFetchLo) || (state_q == StFetchHi)) && !mem_ack_i;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      pc_q        <= PcReset;
      mem_addr_q  <= 16'h0000;
      ir_data_q   <= 16'h0000;
      ir_funsel_q <= 3'b000;
      mem_rd_q    <= 1'b0;
      ir_e_q      <= 1'b0;
      busy_q      <= 1'b0;
      ir_valid_q  <= 1'b0;
      timeout_q   <= 1'b0;
`ifdef IFU_TIMEOUT_EN
      start_pc_q  <= 16'h0000;
      wait_cnt_q  <= 8'd0;
`endif
    end else begin
      // Pulse-type outputs default low every cycle.
      ir_e_q      <= 1'b0;
      ir_funsel_q <= 3'b000;
      ir_data_q   <= 16'h0000;
      ir_valid_q  <= 1'b0;
      timeout_q   <= 1'b0;

      unique case (state_q)
        StIdle, StDone: begin
          state_q <= StIdle;
          if (pc_load_i) begin
            pc_q <= pc_in_i;
          end else if (start_i) begin
            state_q    <= StFetchLo;
            mem_rd_q   <= 1'b1;
            mem_addr_q <= pc_q;
            busy_q     <= 1'b1;
`ifdef IFU_TIMEOUT_EN
            start_pc_q <= pc_q;
            wait_cnt_q <= 8'd0;
`endif
          end
        end
        StFetchLo: begin
          if (mem_ack_i) begin
            state_q     <= StFetchHi;
            ir_e_q      <= 1'b1;
            ir_funsel_q <= FunSelWrLo;
            ir_data_q   <= {8'h00, mem_data_i};
            pc_q        <= pc_inc;
            mem_addr_q  <= pc_inc;
`ifdef IFU_TIMEOUT_EN
            wait_cnt_q  <= 8'd0;
`endif
          end
        end
        StFetchHi: begin
          if (mem_ack_i) begin
            state_q     <= StHiWr;
            ir_e_q      <= 1'b1;
            ir_funsel_q <= FunSelWrHi;
            ir_data_q   <= {8'h00, mem_data_i};
            pc_q        <= pc_inc;
            mem_rd_q    <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        StHiWr: begin
          // Not busy here, so a PC load is honoured; Start waits for DONE.
          state_q    <= StDone;
          ir_valid_q <= 1'b1;
          if (pc_load_i) begin
            pc_q <= pc_in_i;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase

`ifdef IFU_TIMEOUT_EN
      // Later assignments override the case above when the watchdog fires.
      if (waiting) begin
        if (wait_cnt_q == WaitLast) begin
          state_q    <= StIdle;
          mem_rd_q   <= 1'b0;
          busy_q     <= 1'b0;
          pc_q       <= start_pc_q;
          timeout_q  <= 1'b1;
          wait_cnt_q <= 8'd0;
        end else begin
          wait_cnt_q <= wait_cnt_q + 8'd1;
        end
      end
`endif
    end
  end

  assign mem_rd_o    = mem_rd_q;
  assign mem_addr_o  = mem_addr_q;
  assign ir_e_o      = ir_e_q;
  assign ir_funsel_o = ir_funsel_q;
  assign ir_data_o   = ir_data_q;
  assign pc_o        = pc_q;
  assign busy_o      = busy_q;
  assign ir_valid_o  = ir_valid_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: vector table plus corner-case sequences,
// with an IR-write scoreboard fed at stimulus time. Honours IFU_TIMEOUT_EN.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        pc_load = 1'b0;
  logic [15:0] pc_in = 16'h0000;
  logic [7:0]  mem_data = 8'h00;
  logic        mem_ack = 1'b0;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic        ir_e;
  logic [2:0]  ir_funsel;
  logic [15:0] ir_data;
  logic [15:0] pc;
  logic        busy;
  logic        ir_valid;
  logic        timeout;

  always #5 clk = ~clk;

  instruction_fetch_unit #(
    .PcReset(16'h0000),
    .WaitMax(4)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .pc_load_i  (pc_load),
    .pc_in_i    (pc_in),
    .mem_data_i (mem_data),
    .mem_ack_i  (mem_ack),
    .mem_rd_o   (mem_rd),
    .mem_addr_o (mem_addr),
    .ir_e_o     (ir_e),
    .ir_funsel_o(ir_funsel),
    .ir_data_o  (ir_data),
    .pc_o       (pc),
    .busy_o     (busy),
    .ir_valid_o (ir_valid),
    .timeout_o  (timeout)
  );

  typedef struct {
    logic [2:0]  fs;
    logic [15:0] data;
  } wr_t;

  typedef struct {
    logic [15:0] pc;
    logic [7:0]  lo;
    logic [7:0]  hi;
    int          lat;
    logic [15:0] exp_ir;
    logic [15:0] exp_pc;
    int          exp_cyc;
    bit          do_load;
  } vec_t;

  logic [7:0]  mem [0:65535];
  wr_t         wr_q[$];
  logic [15:0] ir_exp_q[$];
  logic [15:0] ir_model = 16'h0000;
  int          total = 0;
  int          bad = 0;
  int          lat = 0;
  int          acks_left = -1;
  int          mcnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory: acks `lat` idle cycles after each request, reading at the current address.
  always @(negedge clk) begin
    if (rst || !mem_rd) begin
      mem_ack = 1'b0;
      mcnt = 0;
    end else if (acks_left != 0 && mcnt >= lat) begin
      mem_ack = 1'b1;
      mem_data = mem[mem_addr];
      mcnt = 0;
      if (acks_left > 0) acks_left--;
    end else begin
      mem_ack = 1'b0;
      mcnt++;
    end
  end

  // Scoreboard: every IR write and every IR_Valid must match an expectation.
  always @(negedge clk) begin
    if (ir_e === 1'b1) begin
      if (wr_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL ir_write: unexpected write fs=%b data=%h", ir_funsel, ir_data);
      end else begin
        wr_t w;
        w = wr_q.pop_front();
        check("ir_funsel", 32'(ir_funsel), 32'(w.fs));
        check("ir_data", 32'(ir_data), 32'(w.data));
        if (ir_funsel == 3'b100) ir_model = {8'h00, ir_data[7:0]};
        else if (ir_funsel == 3'b110) ir_model[15:8] = ir_data[7:0];
      end
    end
    if (ir_valid === 1'b1) begin
      if (ir_exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL ir_valid: unexpected pulse, ir=%h", ir_model);
      end else begin
        check("ir_value", 32'(ir_model), 32'(ir_exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_lo(input logic [15:0] a);
    wr_t w;
    w.fs = 3'b100;
    w.data = {8'h00, mem[a]};
    wr_q.push_back(w);
  endtask

  task automatic push_fetch(input logic [15:0] a);
    wr_t w;
    logic [15:0] a1;
    a1 = a + 16'd1;
    push_lo(a);
    w.fs = 3'b110;
    w.data = {8'h00, mem[a1]};
    wr_q.push_back(w);
    ir_exp_q.push_back({mem[a1], mem[a]});
  endtask

  task automatic load_pc(input logic [15:0] v);
    pc_load = 1'b1;
    pc_in = v;
    tick();
    pc_load = 1'b0;
  endtask

  // Pulses Start for one cycle; cyc = ticks until IR_Valid seen, -1 if budget expires.
  task automatic fetch_wait(input int budget, output int cyc);
    bit seen;
    seen = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (!seen && cyc < budget) begin
      tick();
      cyc++;
      if (ir_valid) seen = 1'b1;
    end
    if (!seen) cyc = -1;
  endtask

  vec_t vecs[5];

  initial begin
    int cyc;
    int n;
    int pulses;
    int tos;
    bit drop;
    bit seen;
    logic [15:0] a;

    vecs[0] = '{16'h0000, 8'h34, 8'h12, 0, 16'h1234, 16'h0002, 4, 1'b0};
    vecs[1] = '{16'hFFFF, 8'hCD, 8'hAB, 0, 16'hABCD, 16'h0001, 4, 1'b1};
    vecs[2] = '{16'h1234, 8'h5A, 8'hA5, 1, 16'hA55A, 16'h1236, 6, 1'b1};
    vecs[3] = '{16'h8000, 8'h00, 8'hFF, 2, 16'hFF00, 16'h8002, 8, 1'b1};
    vecs[4] = '{16'h00FE, 8'h77, 8'h88, 0, 16'h8877, 16'h0100, 4, 1'b1};

    for (int i = 0; i < 65536; i++) mem[i] = 8'(i ^ 8'h5C);

    // Reset state.
    tick();
    tick();
    rst = 1'b0;
    check("rst_pc", 32'(pc), 32'h0000);
    check("rst_mem_rd", 32'(mem_rd), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_ir_e", 32'(ir_e), 32'h0);
    check("rst_ir_valid", 32'(ir_valid), 32'h0);
    check("rst_timeout", 32'(timeout), 32'h0);

    // Vector table: single fetches with varying PC, data and memory latency.
    for (int i = 0; i < 5; i++) begin
      a = vecs[i].pc + 16'd1;
      mem[vecs[i].pc] = vecs[i].lo;
      mem[a] = vecs[i].hi;
      lat = vecs[i].lat;
      if (vecs[i].do_load) begin
        load_pc(vecs[i].pc);
        check("vec_pc_load", 32'(pc), 32'(vecs[i].pc));
      end
      push_fetch(vecs[i].pc);
      fetch_wait(40, cyc);
      check("vec_latency", 32'(cyc), 32'(vecs[i].exp_cyc));
      check("vec_pc_after", 32'(pc), 32'(vecs[i].exp_pc));
      check("vec_ir", 32'(ir_model), 32'(vecs[i].exp_ir));
      tick();
    end

    // Slow memory with Start and PC_Load pulsed mid-fetch.
    lat = 3;
    mem[16'h0200] = 8'h11;
    mem[16'h0201] = 8'h22;
    load_pc(16'h0200);
    push_fetch(16'h0200);
    start = 1'b1;
    tick();
    start = 1'b0;
    pulses = 0;
    for (int c = 1; c <= 20; c++) begin
      if (c <= 3) begin
        check("mid_addr_stable", 32'(mem_addr), 32'h0200);
        check("mid_busy", 32'(busy), 32'h1);
      end
      if (c == 2) begin
        start = 1'b1;
        pc_load = 1'b1;
        pc_in = 16'h5555;
      end
      if (c == 3) begin
        start = 1'b0;
        pc_load = 1'b0;
      end
      tick();
      if (ir_valid) pulses++;
    end
    check("mid_valid_once", 32'(pulses), 32'd1);
    check("mid_pc", 32'(pc), 32'h0202);

    // Start held for three back-to-back zero-wait fetches.
    lat = 0;
    for (int i = 0; i < 6; i++) mem[16'h0300 + 16'(i)] = 8'hA0 + 8'(i);
    load_pc(16'h0300);
    push_fetch(16'h0300);
    push_fetch(16'h0302);
    push_fetch(16'h0304);
    start = 1'b1;
    n = 0;
    drop = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (drop) begin
        start = 1'b0;
        drop = 1'b0;
      end
      if (ir_valid) begin
        n++;
        check("b2b_valid_cycle", 32'(c), 32'(4 * n));
        check("b2b_pc", 32'(pc), 32'(16'h0300 + 16'(2 * n)));
        if (n == 2) drop = 1'b1;
      end
    end
    start = 1'b0;
    check("b2b_count", 32'(n), 32'd3);

    // Reset in FETCH_HI aborts without a high write.
    lat = 3;
    mem[16'h0400] = 8'h3C;
    load_pc(16'h0400);
    push_lo(16'h0400);
    start = 1'b1;
    tick();
    start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      if (ir_e) seen = 1'b1;
    end
    check("rst_hi_reached", 32'(seen), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_hi_pc", 32'(pc), 32'h0000);
    check("rst_hi_mem_rd", 32'(mem_rd), 32'h0);
    check("rst_hi_ir_e", 32'(ir_e), 32'h0);
    check("rst_hi_busy", 32'(busy), 32'h0);
    for (int c = 0; c < 6; c++) tick();

`ifdef IFU_TIMEOUT_EN
    // High byte withheld: watchdog restores PC and pulses Timeout.
    lat = 0;
    mem[16'h0010] = 8'hAA;
    mem[16'h0011] = 8'hBB;
    load_pc(16'h0010);
    push_lo(16'h0010);
    acks_left = 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tos = 0;
    pulses = 0;
    for (int c = 2; c <= 12; c++) begin
      tick();
      if (timeout) begin
        tos++;
        check("to_cycle", 32'(c), 32'd6);
        check("to_pc", 32'(pc), 32'h0010);
        check("to_mem_rd", 32'(mem_rd), 32'h0);
        check("to_busy", 32'(busy), 32'h0);
      end
      if (ir_valid) pulses++;
    end
    check("to_pulses", 32'(tos), 32'd1);
    check("to_no_valid", 32'(pulses), 32'd0);
    acks_left = -1;
`else
    // High byte withheld: fetch waits indefinitely, then completes.
    lat = 0;
    mem[16'h0010] = 8'hAA;
    mem[16'h0011] = 8'hBB;
    load_pc(16'h0010);
    push_fetch(16'h0010);
    acks_left = 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tos = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (timeout) tos++;
    end
    check("nto_no_timeout", 32'(tos), 32'd0);
    check("nto_still_busy", 32'(busy), 32'h1);
    acks_left = -1;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      tick();
      if (ir_valid) seen = 1'b1;
    end
    check("nto_completes", 32'(seen), 32'h1);
    check("nto_pc", 32'(pc), 32'h0012);
`endif

    tick();
    tick();
    check("sb_writes_drained", 32'(wr_q.size()), 32'd0);
    check("sb_valids_drained", 32'(ir_exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
